// File: rtl/psum_axis_serializer_pkg.sv
// Shared definitions for the partial-sum AXI4-Stream serializer: beat math,
// counter widths and the stream FSM states.
package psum_axis_serializer_pkg;

  localparam int PSUM_WIDTH_DEF      = 1280;
  localparam int TDATA_WIDTH_DEF     = 32;
  localparam int FRAME_CNT_WIDTH_DEF = 12;

  // The vector width must be an exact multiple of the beat width.
  function automatic int calc_beats(input int psum_w, input int data_w);
    return psum_w / data_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEATS          = calc_beats(PSUM_WIDTH_DEF, TDATA_WIDTH_DEF);
  localparam int BEAT_CNT_WIDTH = cnt_width(BEATS);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/psum_pingpong_buffer.sv
// Two-entry ping-pong store for partial-sum vectors with capture/release
// bookkeeping and a sticky overflow flag for dropped vectors.
module psum_pingpong_buffer
  import psum_axis_serializer_pkg::*;
#(
  parameter int WIDTH = PSUM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] psum_in,
  input  logic             psum_valid,
  input  logic             rel_en,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count,
  output logic             psum_ready,
  output logic             capture,
  output logic             overflow
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             drop;

  // A full buffer can still accept when the reader frees its entry this cycle.
  assign psum_ready = (count != 2'd2) || rel_en;
  assign capture    = psum_valid && psum_ready;
  assign drop       = psum_valid && !psum_ready;
  assign rd_data    = rd_ptr ? entry1 : entry0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (rel_en)  rd_ptr <= ~rd_ptr;
      case ({capture, rel_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (capture && !wr_ptr) entry0 <= psum_in;
    if (capture &&  wr_ptr) entry1 <= psum_in;
  end

endmodule

// File: rtl/psum_axis_serializer.sv
// Captures wide partial-sum vectors into a ping-pong buffer and streams each one
// LSB-slice first over an AXI4-Stream master, with TLAST closing every frame.
module psum_axis_serializer
  import psum_axis_serializer_pkg::*;
#(
  parameter int PSUM_WIDTH           = PSUM_WIDTH_DEF,
  parameter int C_M_AXIS_TDATA_WIDTH = TDATA_WIDTH_DEF,
  parameter int FRAME_CNT_WIDTH      = FRAME_CNT_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PSUM_WIDTH-1:0]             psum_in,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [FRAME_CNT_WIDTH-1:0]        frame_vectors,
  input  logic                              clear_overflow,
  output logic                              overflow,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy
);

  localparam int NBEATS = calc_beats(PSUM_WIDTH, C_M_AXIS_TDATA_WIDTH);
  localparam int BCW    = cnt_width(NBEATS);
  localparam int DW     = C_M_AXIS_TDATA_WIDTH;
  localparam int FCW    = FRAME_CNT_WIDTH;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

  state_t                state;
  logic                  tvalid_q;
  logic [BCW-1:0]        beat_cnt;
  logic [FCW-1:0]        vec_cnt;
  logic [FCW-1:0]        frame_len;
  logic [FCW-1:0]        len_sample;
  logic [PSUM_WIDTH-1:0] rd_data;
  logic [DW-1:0]         slice;
  logic [1:0]            count;
  logic                  capture;
  logic                  rel_en;
  logic                  handshake;
  logic                  last_beat;
  logic                  last_vec;
  logic                  more;

  psum_pingpong_buffer #(
    .WIDTH(PSUM_WIDTH)
  ) u_buffer (
    .clk           (clk),
    .rst           (rst),
    .psum_in       (psum_in),
    .psum_valid    (psum_valid),
    .rel_en        (rel_en),
    .clear_overflow(clear_overflow),
    .rd_data       (rd_data),
    .count         (count),
    .psum_ready    (psum_ready),
    .capture       (capture),
    .overflow      (overflow)
  );

  assign len_sample = (frame_vectors == '0) ? FCW'(1) : frame_vectors;
  assign handshake  = tvalid_q && M_AXIS_TREADY;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_vec   = (vec_cnt == frame_len - FCW'(1));
  assign rel_en     = handshake && last_beat;
  // Another vector is ready to follow if the other entry is full or filling now.
  assign more       = (count == 2'd2) || capture;

  always_comb begin
    slice = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat_cnt == BCW'(i)) slice = rd_data[i*DW +: DW];
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tvalid_q ? slice : '0;
  assign M_AXIS_TLAST  = tvalid_q && last_beat && last_vec;
  assign M_AXIS_TSTRB  = '1;
  assign busy          = (count != 2'd0);

  // Frame length is sampled whenever a new frame begins, either from idle or
  // when a frame wraps while the next vector is already queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tvalid_q  <= 1'b0;
      beat_cnt  <= '0;
      vec_cnt   <= '0;
      frame_len <= FCW'(1);
    end else begin
      case (state)
        IDLE: begin
          if ((count != 2'd0) || capture) begin
            state    <= SEND;
            tvalid_q <= 1'b1;
            beat_cnt <= '0;
            if (vec_cnt == '0) frame_len <= len_sample;
          end
        end
        SEND: begin
          if (handshake) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (last_vec) begin
                vec_cnt   <= '0;
                frame_len <= len_sample;
              end else begin
                vec_cnt <= vec_cnt + FCW'(1);
              end
              if (!more) begin
                state    <= IDLE;
                tvalid_q <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_axis_serializer.sv
// Self-checking bench: a word-queue scoreboard of accepted vectors predicts
// stream contents, TLAST, occupancy-derived flags and overflow each cycle.
module tb_psum_axis_serializer;

  localparam int PW  = 1280;
  localparam int DW  = 32;
  localparam int FCW = 12;
  localparam int NB  = PW / DW;

  logic           clk = 1'b0;
  logic           rst;
  logic [PW-1:0]  psum_in;
  logic           psum_valid;
  logic           psum_ready;
  logic [FCW-1:0] frame_vectors;
  logic           clear_overflow;
  logic           overflow;
  logic [DW-1:0]  M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TSTRB;
  logic           M_AXIS_TLAST;
  logic           M_AXIS_TVALID;
  logic           M_AXIS_TREADY;
  logic           busy;

  psum_axis_serializer #(
    .PSUM_WIDTH(PW),
    .C_M_AXIS_TDATA_WIDTH(DW),
    .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .psum_in       (psum_in),
    .psum_valid    (psum_valid),
    .psum_ready    (psum_ready),
    .frame_vectors (frame_vectors),
    .clear_overflow(clear_overflow),
    .overflow      (overflow),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted vector becomes NB words in this queue.
  logic [DW-1:0] exp_q[$];
  bit            ov_m;
  int            vif;
  int            len_m = 1;
  int            n_checks;
  int            n_fail;
  int            hs_cnt;
  int            tlast_cnt;

  typedef struct {
    logic pv;
    logic clr;
    logic exp_ready;
    logic exp_ov;
    logic exp_busy;
    logic exp_tvalid;
  } row_t;

  row_t tbl[7];

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic newVector(input bit counting);
    for (int k = 0; k < NB; k++)
      psum_in[k*DW +: DW] = counting ? DW'(k + 1) : DW'($urandom);
  endtask

  function automatic bit pickReady(input int mode, input int i);
    if (mode == 1) return (i % 4 == 0) || (i % 4 == 3);
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input bit pv, input bit tr, input bit clr);
    psum_valid     = pv;
    M_AXIS_TREADY  = tr;
    clear_overflow = clr;
    @(negedge clk);
  endtask

  // Compares this cycle's outputs to the model, then advances model and clock.
  task automatic modelCycle();
    int  cnt;
    bit  exp_v, front_last, exp_last, hs, rel, cap;
    cnt        = (exp_q.size() + NB - 1) / NB;
    exp_v      = cnt > 0;
    front_last = exp_v && ((exp_q.size() - 1) % NB == 0);
    if (exp_v && (exp_q.size() % NB == 0) && vif == 0)
      len_m = (frame_vectors == 0) ? 1 : int'(frame_vectors);
    exp_last = front_last && (vif == len_m - 1);
    checkOutput("tvalid", 32'(M_AXIS_TVALID), 32'(exp_v));
    checkOutput("busy", 32'(busy), 32'(exp_v));
    checkOutput("overflow", 32'(overflow), 32'(ov_m));
    if (exp_v) begin
      checkOutput("tdata", M_AXIS_TDATA, exp_q[0]);
      checkOutput("tlast", 32'(M_AXIS_TLAST), 32'(exp_last));
    end else begin
      checkOutput("tlast_idle", 32'(M_AXIS_TLAST), 32'd0);
    end
    hs  = exp_v && M_AXIS_TREADY;
    rel = hs && front_last;
    checkOutput("psum_ready", 32'(psum_ready), 32'((cnt < 2) || rel));
    cap = psum_valid && ((cnt < 2) || rel);
    if (hs) begin
      hs_cnt++;
      if (exp_last) tlast_cnt++;
      void'(exp_q.pop_front());
      if (front_last) vif = (vif + 1 == len_m) ? 0 : vif + 1;
    end
    if (cap) for (int k = 0; k < NB; k++) exp_q.push_back(psum_in[k*DW +: DW]);
    if (psum_valid && !cap) ov_m = 1'b1;
    else if (clear_overflow) ov_m = 1'b0;
    if (rst) begin
      exp_q.delete();
      ov_m = 1'b0;
      vif  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit pv, input bit tr, input bit clr);
    applyStimulus(pv, tr, clr);
    modelCycle();
  endtask

  task automatic drain(input int mode, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(1'b0, pickReady(mode, n + 1), 1'b0);
      n++;
    end
    checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic clearCounts();
    hs_cnt    = 0;
    tlast_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit sent3;
    rst = 1'b1; psum_valid = 1'b0; clear_overflow = 1'b0; M_AXIS_TREADY = 1'b1;
    frame_vectors = 12'd1; psum_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    checkOutput("rst_tdata", M_AXIS_TDATA, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(psum_ready), 32'd1);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("tstrb", 32'(M_AXIS_TSTRB), 32'hF);

    $display("[TB] single vector");
    clearCounts();
    newVector(1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    drain(0, 100);
    checkOutput("single_beats", 32'(hs_cnt), 32'd40);
    checkOutput("single_tlast", 32'(tlast_cnt), 32'd1);

    $display("[TB] frame of three then one");
    clearCounts();
    frame_vectors = 12'd3;
    for (int v = 0; v < 3; v++) begin
      newVector(1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (49) cycle(1'b0, 1'b1, 1'b0);
    end
    checkOutput("frame3_beats", 32'(hs_cnt), 32'd120);
    checkOutput("frame3_tlast", 32'(tlast_cnt), 32'd1);
    frame_vectors = 12'd1;
    newVector(1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    drain(0, 100);
    checkOutput("frame4_beats", 32'(hs_cnt), 32'd160);
    checkOutput("frame4_tlast", 32'(tlast_cnt), 32'd2);

    $display("[TB] backpressure");
    clearCounts();
    newVector(1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    drain(1, 400);
    checkOutput("bp_beats", 32'(hs_cnt), 32'd40);
    checkOutput("bp_tlast", 32'(tlast_cnt), 32'd1);

    $display("[TB] overflow table");
    tbl[0] = '{pv: 1'b1, clr: 1'b0, exp_ready: 1'b1, exp_ov: 1'b0, exp_busy: 1'b0, exp_tvalid: 1'b0};
    tbl[1] = '{pv: 1'b1, clr: 1'b0, exp_ready: 1'b1, exp_ov: 1'b0, exp_busy: 1'b1, exp_tvalid: 1'b1};
    tbl[2] = '{pv: 1'b1, clr: 1'b0, exp_ready: 1'b0, exp_ov: 1'b0, exp_busy: 1'b1, exp_tvalid: 1'b1};
    tbl[3] = '{pv: 1'b1, clr: 1'b1, exp_ready: 1'b0, exp_ov: 1'b1, exp_busy: 1'b1, exp_tvalid: 1'b1};
    tbl[4] = '{pv: 1'b0, clr: 1'b0, exp_ready: 1'b0, exp_ov: 1'b1, exp_busy: 1'b1, exp_tvalid: 1'b1};
    tbl[5] = '{pv: 1'b0, clr: 1'b1, exp_ready: 1'b0, exp_ov: 1'b1, exp_busy: 1'b1, exp_tvalid: 1'b1};
    tbl[6] = '{pv: 1'b0, clr: 1'b0, exp_ready: 1'b0, exp_ov: 1'b0, exp_busy: 1'b1, exp_tvalid: 1'b1};
    clearCounts();
    for (int r = 0; r < 7; r++) begin
      newVector(1'b0);
      applyStimulus(tbl[r].pv, 1'b0, tbl[r].clr);
      checkOutput($sformatf("tbl%0d_ready", r), 32'(psum_ready), 32'(tbl[r].exp_ready));
      checkOutput($sformatf("tbl%0d_ov", r), 32'(overflow), 32'(tbl[r].exp_ov));
      checkOutput($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
      checkOutput($sformatf("tbl%0d_tvalid", r), 32'(M_AXIS_TVALID), 32'(tbl[r].exp_tvalid));
      modelCycle();
    end
    drain(0, 200);
    checkOutput("ovf_beats", 32'(hs_cnt), 32'd80);

    $display("[TB] capture coinciding with release");
    clearCounts();
    frame_vectors = 12'd3;
    newVector(1'b0); cycle(1'b1, 1'b1, 1'b0);
    newVector(1'b0); cycle(1'b1, 1'b1, 1'b0);
    sent3 = 1'b0;
    n = 0;
    while (!sent3 && n < 100) begin
      if (exp_q.size() == NB + 1) begin
        newVector(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sim_ready", 32'(psum_ready), 32'd1);
        modelCycle();
        sent3 = 1'b1;
      end else begin
        cycle(1'b0, 1'b1, 1'b0);
      end
      n++;
    end
    checkOutput("sim_sent", 32'(sent3), 32'd1);
    drain(0, 200);
    checkOutput("sim_beats", 32'(hs_cnt), 32'd120);
    checkOutput("sim_tlast", 32'(tlast_cnt), 32'd1);
    checkOutput("sim_overflow", 32'(overflow), 32'd0);

    $display("[TB] reset mid-frame");
    newVector(1'b0); cycle(1'b1, 1'b1, 1'b0);
    repeat (49) cycle(1'b0, 1'b1, 1'b0);
    clearCounts();
    newVector(1'b0); cycle(1'b1, 1'b1, 1'b0);
    n = 0;
    while (hs_cnt < 16 && n < 100) begin
      cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("rst_mid_reach", 32'(hs_cnt), 32'd16);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rstmid_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_ready", 32'(psum_ready), 32'd1);
    modelCycle();
    clearCounts();
    frame_vectors = 12'd1;
    newVector(1'b1); cycle(1'b1, 1'b1, 1'b0);
    drain(0, 100);
    checkOutput("rstmid_beats", 32'(hs_cnt), 32'd40);
    checkOutput("rstmid_tlast", 32'(tlast_cnt), 32'd1);

    $display("[TB] zero frame length");
    clearCounts();
    frame_vectors = 12'd0;
    newVector(1'b0); cycle(1'b1, 1'b1, 1'b0);
    drain(0, 100);
    checkOutput("fv0_tlast", 32'(tlast_cnt), 32'd1);

    $display("[TB] random traffic");
    clearCounts();
    frame_vectors = 12'd2;
    for (int i = 0; i < 2500; i++) begin
      newVector(1'b0);
      cycle($urandom_range(0, 99) < 6, pickReady(2, i), $urandom_range(0, 99) < 3);
    end
    drain(0, 300);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
